// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the read/write data-memory controller.
// Holds the arbiter FSM state type, the port-index type and the address
// window served by the 96x8 memory (0x80..0xDF).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index of a requesting port (0 = CPU load/store, 1 = I/O/DMA).
  typedef logic port_idx_t;

  localparam logic [7:0] RW_BASE = 8'd128;
  localparam logic [7:0] RW_LAST = 8'd223;

  // Unsigned window test used for both the write enable and the error flag.
  function automatic logic addr_in_range(input logic [7:0] addr,
                                         input logic [7:0] base,
                                         input logic [7:0] last);
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/rw_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way winner selection.
// Build option RW_ARB_FIXED_PRIO_EN: when defined, port 0 always wins and
// no last-winner input exists; otherwise round-robin on the pointer held
// by the parent.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
`ifndef RW_ARB_FIXED_PRIO_EN
  input  port_idx_t last_winner,
`endif
  output port_idx_t grant
);

`ifdef RW_ARB_FIXED_PRIO_EN
  // Port 0 first; with no request at all the value is ignored by the parent.
  assign grant = req0 ? 1'b0 : req1;
`else
  // A lone requester wins; on a tie the port that lost last time wins.
  assign grant = (req0 && req1) ? ~last_winner : ~req0;
`endif

endmodule

// File: rtl/rw_mem_arbiter.sv
// rw_mem_arbiter: shares the single port of the 96x8 read/write data memory
// between the CPU load/store path (port 0) and the I/O/DMA path (port 1).
// Each transaction runs IDLE -> ACCESS -> RESP, one memory operation each.
// Build option RW_ARB_FIXED_PRIO_EN selects fixed priority (port 0 first)
// instead of the default round-robin arbitration.
module rw_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter logic [7:0] RW_BASE = mem_ctrl_pkg::RW_BASE,
  parameter logic [7:0] RW_LAST = mem_ctrl_pkg::RW_LAST
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_address,
  output logic       mem_WE,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  port_idx_t  r_winner;
  port_idx_t  w_grant;
  logic       w_take;
  logic       w_in_range;

`ifndef RW_ARB_FIXED_PRIO_EN
  port_idx_t  r_last;
`endif

  rr_arb2 u_arb (
    .req0        (req0),
    .req1        (req1),
`ifndef RW_ARB_FIXED_PRIO_EN
    .last_winner (r_last),
`endif
    .grant       (w_grant)
  );

  // Range of the latched address; gates the write strobe and drives err.
  assign w_in_range  = addr_in_range(r_addr, RW_BASE, RW_LAST);
  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;

  // Next-state and all state-decoded outputs; requests only steer w_take.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    mem_WE       = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    err0         = 1'b0;
    err1         = 1'b0;
    rdata0       = 8'h00;
    rdata1       = 8'h00;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_take       = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_WE       = r_we && w_in_range;
        w_state_next = RESP;
      end
      RESP: begin
        if (r_winner == 1'b0) begin
          done0  = 1'b1;
          err0   = !w_in_range;
          rdata0 = (w_in_range && !r_we) ? mem_data_out : 8'h00;
        end else begin
          done1  = 1'b1;
          err1   = !w_in_range;
          rdata1 = (w_in_range && !r_we) ? mem_data_out : 8'h00;
        end
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register plus capture of the winning request at the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_winner <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_winner <= w_grant;
        r_we     <= w_grant ? we1    : we0;
        r_addr   <= w_grant ? addr1  : addr0;
        r_wdata  <= w_grant ? wdata1 : wdata0;
      end
    end
  end

`ifndef RW_ARB_FIXED_PRIO_EN
  // Last-winner pointer moves only on a grant; port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_grant;
    end
  end
`endif

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// Self-checking bench for rw_mem_arbiter with a behavioural 8-bit-address
// synchronous memory. Expected completions are queued per port when a
// request is driven and popped when the matching done pulse appears.
// Honours RW_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_rw_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       done0, done1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic       mem_WE;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] exp_mem [0:255];
  logic [7:0] ram [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  rw_mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .done0        (done0),
    .done1        (done1),
    .err0         (err0),
    .err1         (err1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_address  (mem_address),
    .mem_WE       (mem_WE),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write on WE, registered read of the addressed byte.
  always @(posedge clk) begin
    if (mem_WE) ram[mem_address] <= mem_data_in;
    mem_data_out <= ram[mem_address];
  end

  function automatic logic in_rng(input logic [7:0] a);
    return (a >= 8'h80) && (a <= 8'hDF);
  endfunction

  // Drive a request on port p and queue the completion it must produce.
  task automatic issue(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.err   = !in_rng(a);
    e.rdata = (!w && in_rng(a)) ? exp_mem[a] : 8'h00;
    if (w && in_rng(a)) exp_mem[a] = d;
    if (p == 0) begin
      we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
      q0.push_back(e);
    end else begin
      we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
      q1.push_back(e);
    end
  endtask

  // Wait (bounded) for port p's done; lat counts negedges from the call,
  // so a request raised in an IDLE cycle completes with lat == 2.
  task automatic wait_done(input int p, output int lat, output int we_cnt, output int other,
                           output logic [7:0] rd, output logic er);
    lat = -1; we_cnt = 0; other = 0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (mem_WE) we_cnt++;
      if ((p == 0 && done1) || (p == 1 && done0)) other++;
      if (p == 0 && done0) begin lat = i; rd = rdata0; er = err0; break; end
      if (p == 1 && done1) begin lat = i; rd = rdata1; er = err1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done0, done1, err0, err1, mem_WE} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b want=00000", {done0, done1, err0, err1, mem_WE});
    end
    n_checks++;
    if ({rdata0, rdata1} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rdata got=%h want=0000", {rdata0, rdata1});
    end
    n_checks++;
    if ({mem_address, mem_data_in} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mem_bus got=%h want=0000", {mem_address, mem_data_in});
    end
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({done0, done1, mem_WE} !== 3'b0) begin
      n_fail++; $display("FAIL reset_idle got=%b want=000", {done0, done1, mem_WE});
    end
    $display("reset: released, outputs idle");
  endtask

  task automatic test_write_read();
    int lat, wc, oth; logic [7:0] rd; logic er; exp_t e;
    for (int k = 0; k < 2; k++) begin
      issue(0, (k == 0), 8'h80, 8'hA5);
      wait_done(0, lat, wc, oth, rd, er);
      req0 = 1'b0;
      e = q0.pop_front();
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL wr_latency k=%0d got=%0d want=2", k, lat); end
      n_checks++;
      if (wc != ((k == 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL wr_we_cycles k=%0d got=%0d want=%0d", k, wc, (k == 0) ? 1 : 0);
      end
      n_checks++;
      if ({rd, er} !== {e.rdata, e.err}) begin
        n_fail++; $display("FAIL wr_resp k=%0d got=%h/%b want=%h/%b", k, rd, er, e.rdata, e.err);
      end
      $display("write_read: %s 0x80 lat=%0d rdata0=%h err0=%b", (k == 0) ? "write" : "read", lat, rd, er);
    end
  endtask

  task automatic test_round_robin();
    int lat, wc, oth; logic [7:0] rd; logic er; exp_t e;
    int order[$];
`ifdef RW_ARB_FIXED_PRIO_EN
    int exp_order[5] = '{0, 0, 0, 0, 1};
`else
    int exp_order[5] = '{0, 1, 0, 1, 1};
`endif
    // Seed 0xC0 through port 1 so the pointer favours port 0 next.
    issue(1, 1'b1, 8'hC0, 8'h5A);
    wait_done(1, lat, wc, oth, rd, er);
    req1 = 1'b0;
    e = q1.pop_front();
    n_checks++;
    if ({rd, er} !== {e.rdata, e.err} || lat != 2) begin
      n_fail++; $display("FAIL rr_seed got=%h/%b lat=%0d want=%h/%b lat=2", rd, er, lat, e.rdata, e.err);
    end
    for (int k = 0; k < 5; k++) issue(exp_order[k], 1'b0, 8'hC0, 8'h00);
    for (int c = 0; c < 40 && order.size() < 5; c++) begin
      @(negedge clk);
      if (done0) begin
        order.push_back(0);
        e = q0.pop_front();
        n_checks++;
        if ({rdata0, err0} !== {e.rdata, e.err}) begin
          n_fail++; $display("FAIL rr_resp0 got=%h/%b want=%h/%b", rdata0, err0, e.rdata, e.err);
        end
      end
      if (done1) begin
        order.push_back(1);
        e = q1.pop_front();
        n_checks++;
        if ({rdata1, err1} !== {e.rdata, e.err}) begin
          n_fail++; $display("FAIL rr_resp1 got=%h/%b want=%h/%b", rdata1, err1, e.rdata, e.err);
        end
      end
      if (order.size() == 4 && req0) begin
        @(posedge clk); #1 req0 = 1'b0;
      end
    end
    @(posedge clk); #1 req1 = 1'b0;
    n_checks++;
    if (order.size() != 5) begin
      n_fail++; $display("FAIL rr_count got=%0d want=5", order.size());
    end
    for (int k = 0; k < 5; k++) begin
      if (k < order.size()) begin
        n_checks++;
        if (order[k] != exp_order[k]) begin
          n_fail++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", k, order[k], exp_order[k]);
        end
        $display("round_robin: grant %0d -> port %0d", k, order[k]);
      end
    end
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++; $display("FAIL rr_leftover got=%0d want=0", q0.size() + q1.size());
    end
  endtask

  task automatic test_out_of_range();
    int lat, wc, oth; logic [7:0] rd; logic er; exp_t e;
    int         tp[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    logic       tw[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ta[8] = '{8'hE0, 8'h7F, 8'hDF, 8'hDF, 8'h80, 8'h7F, 8'hE0, 8'hFF};
    logic [7:0] td[8] = '{8'h3C, 8'h00, 8'h77, 8'h00, 8'h00, 8'h55, 8'h00, 8'h12};
    for (int k = 0; k < 8; k++) begin
      issue(tp[k], tw[k], ta[k], td[k]);
      wait_done(tp[k], lat, wc, oth, rd, er);
      if (tp[k] == 0) begin req0 = 1'b0; e = q0.pop_front(); end
      else begin req1 = 1'b0; e = q1.pop_front(); end
      n_checks++;
      if (lat != 2 || oth != 0) begin
        n_fail++; $display("FAIL range_timing k=%0d lat=%0d other=%0d want lat=2 other=0", k, lat, oth);
      end
      n_checks++;
      if (wc != ((tw[k] && in_rng(ta[k])) ? 1 : 0)) begin
        n_fail++; $display("FAIL range_we k=%0d got=%0d want=%0d", k, wc, (tw[k] && in_rng(ta[k])) ? 1 : 0);
      end
      n_checks++;
      if ({rd, er} !== {e.rdata, e.err}) begin
        n_fail++; $display("FAIL range_resp k=%0d got=%h/%b want=%h/%b", k, rd, er, e.rdata, e.err);
      end
      $display("out_of_range: port%0d %s addr=%h rdata=%h err=%b we_cycles=%0d",
               tp[k], tw[k] ? "wr" : "rd", ta[k], rd, er, wc);
    end
  endtask

  task automatic test_drop_req();
    int lat, wc, oth, extra; logic [7:0] rd; logic er; exp_t e;
    issue(0, 1'b0, 8'h80, 8'h00);
    @(posedge clk); #1 req0 = 1'b0;  // just after the grant edge
    wait_done(0, lat, wc, oth, rd, er);
    e = q0.pop_front();
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL drop_latency got=%0d want=1", lat); end
    n_checks++;
    if ({rd, er} !== {e.rdata, e.err}) begin
      n_fail++; $display("FAIL drop_resp got=%h/%b want=%h/%b", rd, er, e.rdata, e.err);
    end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done0 || done1 || mem_WE) extra++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL drop_extra got=%0d want=0", extra); end
    $display("drop_req: done0 once rdata0=%h extra_activity=%0d", rd, extra);
  endtask

  task automatic test_back_to_back();
    int lat, wc, oth; logic [7:0] rd; logic er; exp_t e;
    for (int k = 1; k < 6; k++) begin
      issue(1, 1'b1, 8'h80 + 8'(k), 8'h10 + 8'(k));
      wait_done(1, lat, wc, oth, rd, er);
      req1 = 1'b0;
      e = q1.pop_front();
    end
    issue(0, 1'b0, 8'h80, 8'h00);
    for (int k = 0; k < 6; k++) begin
      wait_done(0, lat, wc, oth, rd, er);
      e = q0.pop_front();
      if (k < 5) issue(0, 1'b0, 8'h81 + 8'(k), 8'h00);
      else req0 = 1'b0;
      n_checks++;
      if (lat != 2) begin n_fail++; $display("FAIL b2b_spacing k=%0d got=%0d want=2", k, lat); end
      n_checks++;
      if ({rd, er} !== {e.rdata, e.err}) begin
        n_fail++; $display("FAIL b2b_resp k=%0d got=%h/%b want=%h/%b", k, rd, er, e.rdata, e.err);
      end
      $display("back_to_back: read %h rdata0=%h lat=%0d", 8'h80 + 8'(k), rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, wc, oth; logic [7:0] rd; logic er; exp_t e;
    issue(0, 1'b1, 8'h90, 8'h11);
    wait_done(0, lat, wc, oth, rd, er);
    req0 = 1'b0;
    e = q0.pop_front();
    // Abandoned write: driven directly so the model keeps 0x11.
    we0 = 1'b1; addr0 = 8'h90; wdata0 = 8'h99; req0 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (mem_WE !== 1'b1 || mem_address !== 8'h90) begin
      n_fail++; $display("FAIL mid_access we=%b addr=%h want we=1 addr=90", mem_WE, mem_address);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_WE !== 1'b0) begin n_fail++; $display("FAIL mid_we_drop got=%b want=0", mem_WE); end
    req0 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done0, done1} !== 2'b00) begin n_fail++; $display("FAIL mid_no_done got=%b want=00", {done0, done1}); end
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 1'b0, 8'h90, 8'h00);
    wait_done(0, lat, wc, oth, rd, er);
    req0 = 1'b0;
    e = q0.pop_front();
    n_checks++;
    if ({rd, er} !== {e.rdata, e.err} || lat != 2) begin
      n_fail++; $display("FAIL mid_readback got=%h/%b lat=%0d want=%h/%b lat=2", rd, er, lat, e.rdata, e.err);
    end
    $display("reset_mid: readback 0x90 rdata0=%h", rd);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_out_of_range();
    test_drop_req();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
